// File: rtl/enet_nios_bus_pkg.sv
// enet_nios_bus_pkg
// Shared types and constants for the Ethernet controller register-bus arbiter:
// the chip-select sequencer state encoding, the width of its cycle counter,
// and the legal range of the programmable setup/strobe/hold counts.
package enet_nios_bus_pkg;

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned CYC_MIN = 1;
    localparam int unsigned CYC_MAX = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_e;

endpackage

// File: rtl/enet_nios_rr_arb2.sv
// enet_nios_rr_arb2
// Two-input round-robin selector. With one requester active it wins; with both
// active the one that did not win last time wins. The last winner is only
// recorded when grant_en_i allows a grant to be taken.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   req_i[1:0]      request per requester
//   grant_en_i      the consumer is able to accept a grant this cycle
//   grant_valid_c   some requester is asking (combinational)
//   grant_idx_c     index of the winning requester (combinational)
module enet_nios_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       grant_en_i,
    output logic       grant_valid_c,
    output logic       grant_idx_c
);

    logic last_grant_q;

    // Winner selection: a lone requester wins, a tie goes to the other one.
    always_comb begin
        grant_valid_c = |req_i;
        if (req_i == 2'b11) begin
            grant_idx_c = ~last_grant_q;
        end else begin
            grant_idx_c = req_i[1];
        end
    end

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else if (grant_en_i && grant_valid_c) begin
            last_grant_q <= grant_idx_c;
        end
    end

endmodule

// File: rtl/enet_nios_bus_arbiter.sv
// enet_nios_bus_arbiter
// Shares the external Ethernet controller register bus between the Nios data
// master (requester 0) and the packet DMA engine (requester 1). The winner's
// command is latched in IDLE and one asynchronous chip-select cycle is run:
// SETUP (cs_n low, address valid), STROBE (rd_n or wr_n low), HOLD (strobes
// high). A one-cycle ack goes to the winner in the last HOLD cycle.
// Ports:
//   clk, aclr            clock, asynchronous active-high reset
//   req/we[1:0]          per-requester request and direction (1 = write)
//   addr, wdata          requester n at [n*W +: W]
//   ack[1:0], rdata      completion pulse and last read data
//   enet_cs_n/rd_n/wr_n  active-low chip select and strobes
//   enet_addr/dout/doe   address, write data and output enable to the pads
//   enet_din             read data from the pads
module enet_nios_bus_arbiter #(
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 3,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic                clk,
    input  logic                aclr,
    input  logic [1:0]          req,
    input  logic [1:0]          we,
    input  logic [2*ADDR_W-1:0] addr,
    input  logic [2*DATA_W-1:0] wdata,
    output logic [1:0]          ack,
    output logic [DATA_W-1:0]   rdata,
    output logic                enet_cs_n,
    output logic                enet_rd_n,
    output logic                enet_wr_n,
    output logic [ADDR_W-1:0]   enet_addr,
    output logic [DATA_W-1:0]   enet_dout,
    output logic                enet_doe,
    input  logic [DATA_W-1:0]   enet_din
);

    import enet_nios_bus_pkg::*;

    if (SETUP_CYC < CYC_MIN || SETUP_CYC > CYC_MAX) begin : g_bad_setup
        $error("enet_nios_bus_arbiter: SETUP_CYC must be in 1..15");
    end
    if (STROBE_CYC < CYC_MIN || STROBE_CYC > CYC_MAX) begin : g_bad_strobe
        $error("enet_nios_bus_arbiter: STROBE_CYC must be in 1..15");
    end
    if (HOLD_CYC < CYC_MIN || HOLD_CYC > CYC_MAX) begin : g_bad_hold
        $error("enet_nios_bus_arbiter: HOLD_CYC must be in 1..15");
    end

    // Counter reload values: each timed state lasts N cycles, counting N-1..0.
    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               win_q;
    logic               we_q;
    logic [1:0]         ack_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               cs_n_q;
    logic               rd_n_q;
    logic               wr_n_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  dout_q;
    logic               doe_q;

    logic               grant_valid_c;
    logic               grant_idx_c;
    logic [ADDR_W-1:0]  sel_addr_c;
    logic [DATA_W-1:0]  sel_wdata_c;
    logic [1:0]         win_onehot_c;

    enet_nios_rr_arb2 u_arb (
        .clk           (clk),
        .rst           (aclr),
        .req_i         (req),
        .grant_en_i    (state_q == IDLE),
        .grant_valid_c (grant_valid_c),
        .grant_idx_c   (grant_idx_c)
    );

    // Command of the requester that wins this cycle.
    always_comb begin
        sel_addr_c   = grant_idx_c ? addr[2*ADDR_W-1:ADDR_W]  : addr[ADDR_W-1:0];
        sel_wdata_c  = grant_idx_c ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
        win_onehot_c = {win_q, ~win_q};
    end

    // Chip-select sequencer. Pin registers are loaded for the state being
    // entered, so each pin level lines up with the state it belongs to.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            win_q   <= 1'b0;
            we_q    <= 1'b0;
            ack_q   <= '0;
            rdata_q <= '0;
            cs_n_q  <= 1'b1;
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            addr_q  <= '0;
            dout_q  <= '0;
            doe_q   <= 1'b0;
        end else begin
            ack_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (grant_valid_c) begin
                        state_q <= SETUP;
                        cnt_q   <= SETUP_LD;
                        win_q   <= grant_idx_c;
                        we_q    <= we[grant_idx_c];
                        addr_q  <= sel_addr_c;
                        dout_q  <= sel_wdata_c;
                        doe_q   <= we[grant_idx_c];
                        cs_n_q  <= 1'b0;
                    end
                end
                SETUP: begin
                    if (cnt_q == '0) begin
                        state_q <= STROBE;
                        cnt_q   <= STROBE_LD;
                        rd_n_q  <= we_q;
                        wr_n_q  <= ~we_q;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                STROBE: begin
                    if (cnt_q == '0) begin
                        state_q <= HOLD;
                        cnt_q   <= HOLD_LD;
                        rd_n_q  <= 1'b1;
                        wr_n_q  <= 1'b1;
                        // rd_n is still low at this edge, so enet_din is settled.
                        if (!we_q) begin
                            rdata_q <= enet_din;
                        end
                        // A single HOLD cycle is also the last one.
                        if (HOLD_LD == '0) begin
                            ack_q <= win_onehot_c;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                        cs_n_q  <= 1'b1;
                        doe_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            ack_q <= win_onehot_c;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign enet_cs_n = cs_n_q;
    assign enet_rd_n = rd_n_q;
    assign enet_wr_n = wr_n_q;
    assign enet_addr = addr_q;
    assign enet_dout = dout_q;
    assign enet_doe  = doe_q;

endmodule

// File: tb/tb_enet_nios_bus_arbiter.sv
// tb_enet_nios_bus_arbiter
// Randomised two-requester traffic against a register-file model of the
// Ethernet chip. A reference process predicts each grant from the arbitration
// rules and the fixed transaction period; a monitor compares pins, ack and
// rdata cycle by cycle. Directed sections cover reset mid-strobe, command
// changes during STROBE and a non-default timing instance.
module tb_enet_nios_bus_arbiter;

    localparam int unsigned AW  = 4;
    localparam int unsigned DW  = 16;
    localparam int unsigned S   = 1;
    localparam int unsigned ST  = 3;
    localparam int unsigned H   = 1;
    localparam int unsigned P   = 1 + S + ST + H;
    localparam int unsigned S2  = 2;
    localparam int unsigned ST2 = 5;
    localparam int unsigned H2  = 3;
    localparam int unsigned NRAND = 3000;

    typedef struct {
        int           who;
        bit           wr;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        logic [DW-1:0] rd;
        int           t0;
    } txn_t;

    logic            clk = 1'b0;
    logic            aclr = 1'b1;
    logic [1:0]      req = '0;
    logic [1:0]      we = '0;
    logic [2*AW-1:0] addr = '0;
    logic [2*DW-1:0] wdata = '0;
    logic [1:0]      ack;
    logic [DW-1:0]   rdata;
    logic            cs_n, rd_n, wr_n, enet_doe;
    logic [AW-1:0]   enet_addr;
    logic [DW-1:0]   enet_dout;
    logic [DW-1:0]   enet_din;

    logic [1:0]      req2 = '0;
    logic [1:0]      we2 = '0;
    logic [2*AW-1:0] addr2 = '0;
    logic [2*DW-1:0] wdata2 = '0;
    logic [1:0]      ack2;
    logic [DW-1:0]   rdata2;
    logic            cs2_n, rd2_n, wr2_n, doe2;
    logic [AW-1:0]   enet_addr2;
    logic [DW-1:0]   dout2;
    logic [DW-1:0]   din2;

    logic [DW-1:0]   chip_mem [16];
    txn_t            sb [$];
    int              grant_cnt [2];
    int              cyc = 0;
    int              vecs = 0;
    int              errs = 0;

    int              busy [2];
    int              gap [2];
    int              age [2];
    int              gstart [2];

    enet_nios_bus_arbiter dut (
        .clk(clk), .aclr(aclr), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack), .rdata(rdata), .enet_cs_n(cs_n), .enet_rd_n(rd_n),
        .enet_wr_n(wr_n), .enet_addr(enet_addr), .enet_dout(enet_dout),
        .enet_doe(enet_doe), .enet_din(enet_din)
    );

    enet_nios_bus_arbiter #(.SETUP_CYC(S2), .STROBE_CYC(ST2), .HOLD_CYC(H2)) dut2 (
        .clk(clk), .aclr(aclr), .req(req2), .we(we2), .addr(addr2), .wdata(wdata2),
        .ack(ack2), .rdata(rdata2), .enet_cs_n(cs2_n), .enet_rd_n(rd2_n),
        .enet_wr_n(wr2_n), .enet_addr(enet_addr2), .enet_dout(dout2),
        .enet_doe(doe2), .enet_din(din2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] init_val(input int i);
        return DW'(i * 4951) ^ 16'hA5C3;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Chip register file; read data is only meaningful while the read strobe is low.
    assign enet_din = (!cs_n && !rd_n) ? chip_mem[enet_addr] : ~chip_mem[enet_addr];
    assign din2     = (!cs2_n && !rd2_n) ? 16'hBEEF : 16'h0BAD;

    initial begin
        for (int i = 0; i < 16; i++) chip_mem[i] = init_val(i);
        forever begin
            @(posedge clk);
            if (!cs_n && !wr_n) chip_mem[enet_addr] = enet_dout;
        end
    end

    // Reference: a grant happens in any cycle the bus is free and a request is
    // present; the bus is then busy for P-1 cycles and free again at t0+P.
    initial begin
        logic [DW-1:0] m_mem [16];
        int   m_last;
        int   m_next_free;
        int   w;
        txn_t t;
        for (int i = 0; i < 16; i++) m_mem[i] = init_val(i);
        m_last = 1;
        m_next_free = 0;
        forever begin
            @(negedge clk);
            if (aclr) begin
                sb.delete();
                m_last = 1;
                m_next_free = 0;
            end else if (cyc >= m_next_free && req != 2'b00) begin
                if (req == 2'b11) w = 1 - m_last;
                else w = req[1] ? 1 : 0;
                t.who = w;
                t.wr  = we[w];
                t.a   = (w == 1) ? addr[2*AW-1:AW] : addr[AW-1:0];
                t.wd  = (w == 1) ? wdata[2*DW-1:DW] : wdata[DW-1:0];
                t.t0  = cyc;
                t.rd  = '0;
                if (t.wr) m_mem[t.a] = t.wd;
                else t.rd = m_mem[t.a];
                sb.push_back(t);
                m_last = w;
                m_next_free = cyc + P;
                grant_cnt[w]++;
            end
        end
    end

    // Monitor: cycle k of a transaction is k cycles after its grant cycle.
    initial begin
        logic [DW-1:0] m_rdata;
        logic [1:0]    oh;
        txn_t t;
        int   k;
        bit   act;
        bit   strb;
        m_rdata = '0;
        forever begin
            @(negedge clk);
            if (aclr) begin
                m_rdata = '0;
            end else begin
                act = 1'b0;
                k = 0;
                if (sb.size() > 0) begin
                    t = sb[0];
                    k = cyc - t.t0;
                    act = (k >= 1 && k <= int'(P) - 1);
                end
                if (act) begin
                    strb = (k >= 1 + int'(S) && k <= int'(S + ST));
                    chk("cs_n_active", cs_n, 0);
                    chk("rd_n", rd_n, !(!t.wr && strb));
                    chk("wr_n", wr_n, !(t.wr && strb));
                    chk("enet_addr", enet_addr, t.a);
                    chk("enet_doe", enet_doe, t.wr);
                    if (t.wr) chk("enet_dout", enet_dout, t.wd);
                    oh = (k == int'(P) - 1) ? ((t.who == 1) ? 2'b10 : 2'b01) : 2'b00;
                    chk("ack", ack, oh);
                    if (k == int'(P) - 1) begin
                        if (!t.wr) m_rdata = t.rd;
                        chk("rdata_ack", rdata, m_rdata);
                        void'(sb.pop_front());
                    end
                end else begin
                    chk("cs_n_idle", cs_n, 1);
                    chk("strobes_idle", {rd_n, wr_n}, 2'b11);
                    chk("doe_idle", enet_doe, 0);
                    chk("ack_idle", ack, 0);
                    chk("rdata_idle", rdata, m_rdata);
                end
            end
        end
    end

    task automatic start_cmd(input int n);
        req[n] = 1'b1;
        we[n]  = 1'($urandom_range(0, 1));
        addr[n*AW +: AW]  = AW'($urandom);
        wdata[n*DW +: DW] = DW'($urandom);
        gstart[n] = grant_cnt[n];
        age[n]  = 0;
        busy[n] = 1;
    endtask

    task automatic scramble_cmd(input int n);
        we[n] = ~we[n];
        addr[n*AW +: AW]  = AW'($urandom);
        wdata[n*DW +: DW] = DW'($urandom);
    endtask

    initial begin
        logic [1:0] a;
        bit seen;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", ack, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_enet_addr", enet_addr, 0);
        chk("rst_enet_dout", enet_dout, 0);
        chk("rst_doe", enet_doe, 0);
        chk("rst_pins", {cs_n, rd_n, wr_n}, 3'b111);
        chk("rst_dut2_pins", {cs2_n, rd2_n, wr2_n, doe2}, 4'b1110);
        aclr = 1'b0;

        // Random traffic from both requesters
        for (int n = 0; n < 2; n++) begin
            busy[n] = 0;
            gap[n]  = $urandom_range(0, 2);
        end
        for (int it = 0; it < int'(NRAND); it++) begin
            @(negedge clk);
            a = ack;
            @(posedge clk);
            #1;
            for (int n = 0; n < 2; n++) begin
                if (busy[n] != 0) begin
                    age[n]++;
                    if (a[n]) begin
                        busy[n] = 0;
                        gap[n] = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
                        if (gap[n] == 0) start_cmd(n);
                        else req[n] = 1'b0;
                    end else if (age[n] > 4 * int'(P) + 4) begin
                        vecs++;
                        errs++;
                        $display("FAIL ack_wait: requester %0d waited %0d cycles, limit %0d", n, age[n], 4 * P + 4);
                        busy[n] = 0;
                        gap[n] = 1;
                        req[n] = 1'b0;
                    end else if (grant_cnt[n] != gstart[n]) begin
                        if ($urandom_range(0, 3) == 0) scramble_cmd(n);
                        if ($urandom_range(0, 7) == 0) req[n] = 1'b0;
                    end
                end else begin
                    if (gap[n] > 0) gap[n]--;
                    if (gap[n] == 0) start_cmd(n);
                end
            end
        end
        req = '0;
        repeat (2 * P) @(posedge clk);
        #1;

        // Reset in the middle of a write strobe
        req = 2'b10;
        we  = 2'b10;
        addr[2*AW-1:AW]  = 4'h7;
        wdata[2*DW-1:DW] = 16'h1234;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_wr_n", wr_n, 0);
        chk("pre_rst_cs_n", cs_n, 0);
        aclr = 1'b1;
        #1;
        chk("async_wr_n", wr_n, 1);
        chk("async_cs_n", cs_n, 1);
        chk("async_doe", enet_doe, 0);
        chk("async_ack", ack, 0);
        req = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("in_rst_ack", ack, 0);

        // Read after release; address changes during STROBE must not leak out
        aclr = 1'b0;
        req  = 2'b01;
        we   = 2'b00;
        addr[AW-1:0] = 4'h3;
        repeat (3) @(posedge clk);
        #1;
        addr[AW-1:0] = 4'h9;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (ack[0]) seen = 1'b1;
        end
        chk("ack_after_reset", seen, 1);
        @(posedge clk);
        #1;
        req = '0;
        repeat (P) @(posedge clk);
        #1;

        // Non-default timing: single read on the second instance
        req2 = 2'b01;
        we2  = 2'b00;
        addr2[AW-1:0] = 4'h3;
        for (int k = 1; k <= int'(S2 + ST2 + H2) + 2; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) req2 = '0;
            @(negedge clk);
            chk("v_cs_n", cs2_n, (k <= int'(S2 + ST2 + H2)) ? 1'b0 : 1'b1);
            chk("v_rd_n", rd2_n, (k >= int'(S2) + 1 && k <= int'(S2 + ST2)) ? 1'b0 : 1'b1);
            chk("v_wr_n", wr2_n, 1);
            chk("v_ack", ack2, (k == int'(S2 + ST2 + H2)) ? 2'b01 : 2'b00);
            if (k <= int'(S2 + ST2 + H2)) chk("v_enet_addr", enet_addr2, 4'h3);
            if (k > int'(S2 + ST2 + H2)) chk("v_rdata", rdata2, 16'hBEEF);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
